// File: rtl/adv_input_stage.sv
// rtl/adv_input_stage.sv - button synchroniser, debounce and one-at-a-time command issue
module adv_input_stage #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 18,
   parameter int PULSE_CYCLES    = 2,
   parameter int GAP_CYCLES      = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   input  logic btn_s,
   input  logic btn_e,
   input  logic btn_w,
   input  logic sw,
   input  logic clear_inv,
   input  logic lock,
   output logic n,
   output logic s,
   output logic e,
   output logic w,
   output logic v,
   output logic busy
);

   // Timer must hold the larger of PULSE_CYCLES-1 and GAP_CYCLES-1.
   localparam int TW = $clog2((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES + 1 : GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]    PULSE_LAST = TW'(PULSE_CYCLES - 1);
   localparam bit               HAS_GAP    = (GAP_CYCLES > 0);
   localparam logic [TW-1:0]    GAP_LAST   = HAS_GAP ? TW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Channel index 0..3 = n, s, e, w; lower index has higher priority.
   logic [3:0]       raw;
   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       stable;
   logic [CNT_W-1:0] db_cnt [4];
   logic [3:0]       mismatch;
   logic [3:0]       flip;
   logic [3:0]       rise;

   logic [3:0]       pending;
   logic [3:0]       pending_next;
   logic [3:0]       grant;
   logic [3:0]       cmd;
   logic [3:0]       cmd_next;
   logic [TW-1:0]    tcnt;
   logic [TW-1:0]    tcnt_next;
   state_t           state;
   state_t           state_next;

   assign raw = {btn_w, btn_e, btn_s, btn_n};

   // Two-flop synchroniser for the asynchronous buttons.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // A channel flips once its synchronised value has disagreed for DEBOUNCE_CYCLES edges in a row.
   always_comb begin
      mismatch = sync2 ^ stable;
      flip     = '0;
      for (int i = 0; i < 4; i++) begin
         flip[i] = mismatch[i] && (db_cnt[i] == DB_LAST);
      end
      rise = flip & ~stable;
   end

   // Debounce state: stable level plus consecutive-mismatch counter per channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         stable <= stable ^ flip;
         for (int i = 0; i < 4; i++) begin
            if (mismatch[i] && !flip[i]) begin
               db_cnt[i] <= db_cnt[i] + CNT_W'(1);
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Command FSM: pick the highest-priority pending press, hold it, then enforce the gap.
   always_comb begin
      state_next = state;
      cmd_next   = cmd;
      tcnt_next  = tcnt;
      grant      = '0;
      case (state)
         ST_IDLE: begin
            if (!lock && (pending != 4'b0000)) begin
               // Isolate the lowest set bit, i.e. the highest-priority request.
               grant      = pending & (~pending + 4'd1);
               cmd_next   = grant;
               tcnt_next  = PULSE_LAST;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tcnt == '0) begin
               cmd_next = '0;
               if (HAS_GAP) begin
                  tcnt_next  = GAP_LAST;
                  state_next = ST_GAP;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               tcnt_next = tcnt - TW'(1);
            end
         end
         ST_GAP: begin
            if (tcnt == '0) begin
               state_next = ST_IDLE;
            end else begin
               tcnt_next = tcnt - TW'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
            cmd_next   = '0;
            tcnt_next  = '0;
         end
      endcase
      // A press on a channel that is already pending is absorbed; lock flushes everything.
      if (lock) begin
         pending_next = '0;
      end else begin
         pending_next = (pending | rise) & ~grant;
      end
   end

   // FSM, command register and pending flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cmd     <= '0;
         tcnt    <= '0;
         pending <= '0;
      end else begin
         state   <= state_next;
         cmd     <= cmd_next;
         tcnt    <= tcnt_next;
         pending <= pending_next;
      end
   end

   // Sword latch; an inventory clear beats a simultaneous pickup.
   always_ff @(posedge clk) begin
      if (reset) begin
         v <= 1'b0;
      end else if (clear_inv) begin
         v <= 1'b0;
      end else if (sw) begin
         v <= 1'b1;
      end
   end

   assign n    = cmd[0];
   assign s    = cmd[1];
   assign e    = cmd[2];
   assign w    = cmd[3];
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_adv_input_stage.sv
// tb/tb_adv_input_stage.sv - randomized and directed checks of adv_input_stage against a timeline model
module tb_adv_input_stage;

   localparam int D = 4;
   localparam int P = 2;
   localparam int G = 2;
   localparam int MAXE = 8192;

   logic clk = 1'b0;
   logic reset, btn_n, btn_s, btn_e, btn_w, sw, clear_inv, lock;
   logic n, s, e, w, v, busy;

   always #5 clk = ~clk;

   adv_input_stage #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(18),
      .PULSE_CYCLES(P),
      .GAP_CYCLES(G)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn_n(btn_n),
      .btn_s(btn_s),
      .btn_e(btn_e),
      .btn_w(btn_w),
      .sw(sw),
      .clear_inv(clear_inv),
      .lock(lock),
      .n(n),
      .s(s),
      .e(e),
      .w(w),
      .v(v),
      .busy(busy)
   );

   int tests = 0;
   int fails = 0;
   int edge_no = 0;

   // Reference model: raw-sample history window, stable levels, pending set, issue timeline.
   bit [3:0] samp [$];
   bit [3:0] m_stable;
   bit [3:0] m_pending;
   bit       m_v;
   int       issue_t;
   int       issue_ch;
   int       next_free;

   logic [3:0] obs      [MAXE];
   logic       obs_busy [MAXE];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      samp.delete();
      for (int i = 0; i <= D; i++) samp.push_back(4'b0000);
      m_stable  = '0;
      m_pending = '0;
      m_v       = 1'b0;
      issue_t   = -1000;
      issue_ch  = 0;
      next_free = 0;
   endtask

   task automatic model_step();
      bit [3:0] rawv;
      bit [3:0] rise;
      bit [3:0] grant;
      bit       all_diff;
      rawv = {btn_w, btn_e, btn_s, btn_n};
      if (reset) begin
         model_reset();
         return;
      end
      // Stable flips when the D samples seen by the synchroniser output all disagree with it.
      rise = '0;
      for (int ch = 0; ch < 4; ch++) begin
         all_diff = 1'b1;
         for (int i = 0; i < D; i++) begin
            if (samp[i][ch] == m_stable[ch]) all_diff = 1'b0;
         end
         if (all_diff) begin
            if (!m_stable[ch]) rise[ch] = 1'b1;
            m_stable[ch] = ~m_stable[ch];
         end
      end
      grant = '0;
      if (edge_no >= next_free && !lock && m_pending != 0) begin
         for (int ch = 3; ch >= 0; ch--) begin
            if (m_pending[ch]) issue_ch = ch;
         end
         grant[issue_ch] = 1'b1;
         issue_t   = edge_no;
         next_free = edge_no + P + G + 1;
      end
      m_pending = lock ? 4'b0000 : ((m_pending | rise) & ~grant);
      samp.push_back(rawv);
      while (samp.size() > D + 1) void'(samp.pop_front());
      if (clear_inv) m_v = 1'b0;
      else if (sw)   m_v = 1'b1;
   endtask

   task automatic cycle();
      logic [3:0] exp_cmd;
      logic       exp_busy;
      logic [3:0] got_cmd;
      @(posedge clk);
      edge_no++;
      model_step();
      #1;
      exp_cmd  = (edge_no >= issue_t && edge_no < issue_t + P) ? (4'b0001 << issue_ch) : 4'b0000;
      exp_busy = (edge_no >= issue_t && edge_no < issue_t + P + G);
      got_cmd  = {w, e, s, n};
      chk("cmd", 32'(got_cmd), 32'(exp_cmd));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("v", 32'(v), 32'(m_v));
      chk("onehot", 32'($countones(got_cmd) <= 1), 32'd1);
      if (edge_no < MAXE) begin
         obs[edge_no]      = got_cmd;
         obs_busy[edge_no] = busy;
      end
      @(negedge clk);
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) cycle();
   endtask

   function automatic logic any_busy(input int from, input int to);
      logic r = 1'b0;
      for (int i = from; i <= to; i++) r = r | obs_busy[i];
      return r;
   endfunction

   int t1, t2, t3, t4, t5, t5w;
   bit [3:0] rb;

   initial begin
      reset = 1'b1; btn_n = 0; btn_s = 0; btn_e = 0; btn_w = 0;
      sw = 0; clear_inv = 0; lock = 0;
      model_reset();
      @(negedge clk);
      run(2);
      chk("rst_cmd", 32'({w, e, s, n}), 32'd0);
      chk("rst_v", 32'(v), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      run(2);

      // Held east press: high after edges 7 and 8, low after 9.
      btn_e = 1; t1 = edge_no + 1;
      run(12);
      btn_e = 0;
      run(10);
      chk("t1_before", 32'(obs[t1 + 5]), 32'h0);
      chk("t1_e7", 32'(obs[t1 + 6]), 32'h4);
      chk("t1_e8", 32'(obs[t1 + 7]), 32'h4);
      chk("t1_e9", 32'(obs[t1 + 8]), 32'h0);

      // Three-cycle glitch is rejected.
      btn_e = 1; t2 = edge_no + 1;
      run(3);
      btn_e = 0;
      run(15);
      chk("t2_glitch", 32'(any_busy(t2, t2 + 17)), 32'd0);

      // Simultaneous south and west: south first, west 5 cycles later.
      btn_s = 1; btn_w = 1; t3 = edge_no + 1;
      run(20);
      btn_s = 0; btn_w = 0;
      run(12);
      chk("t3_s", 32'(obs[t3 + 6]), 32'h2);
      chk("t3_gap", 32'(obs[t3 + 10]), 32'h0);
      chk("t3_w", 32'(obs[t3 + 11]), 32'h8);

      // Reset during north issue.
      sw = 1; run(1); sw = 0;
      btn_n = 1; t4 = edge_no + 1;
      run(7);
      chk("t4_n_on", 32'(obs[t4 + 6]), 32'h1);
      reset = 1; btn_n = 0;
      run(1);
      reset = 0;
      chk("t4_n_off", 32'({w, e, s, n}), 32'd0);
      chk("t4_v", 32'(v), 32'd0);
      run(20);
      chk("t4_quiet", 32'(any_busy(t4 + 8, t4 + 26)), 32'd0);

      // Lock after east is pending suppresses it; west works once unlocked.
      btn_e = 1; t5 = edge_no + 1;
      run(6);
      lock = 1;
      run(3);
      btn_e = 0;
      run(8);
      lock = 0;
      run(4);
      chk("t5_locked", 32'(any_busy(t5, t5 + 20)), 32'd0);
      btn_w = 1; t5w = edge_no + 1;
      run(12);
      btn_w = 0;
      run(10);
      chk("t5_w", 32'(obs[t5w + 6]), 32'h8);

      // Sword latch set and clear-wins.
      sw = 1; run(1); sw = 0;
      chk("t6_v_set", 32'(v), 32'd1);
      run(3);
      chk("t6_v_hold", 32'(v), 32'd1);
      sw = 1; clear_inv = 1; run(1); sw = 0; clear_inv = 0;
      chk("t6_v_clr", 32'(v), 32'd0);
      run(2);

      // Random traffic.
      rb = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int ch = 0; ch < 4; ch++) begin
            if ($urandom_range(0, 9) == 0) rb[ch] = ~rb[ch];
         end
         {btn_w, btn_e, btn_s, btn_n} = rb;
         sw        = ($urandom_range(0, 15) == 0);
         clear_inv = ($urandom_range(0, 31) == 0);
         if ($urandom_range(0, 59) == 0) lock = ~lock;
         reset     = ($urandom_range(0, 299) == 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
